// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, LSB-first payload, optional even parity, stop bit.
// Reports each frame with a one-cycle valid pulse qualified by parity and framing flags.
module serial_frame_receiver #(
  parameter int DATA_BITS = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] payload;
  logic                 parity_bit;
  logic                 last_bit;
  logic                 start_en;
  logic                 shift_en;
  logic                 parity_en;
  logic                 load_en;

  assign last_bit = (bit_cnt == CW'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!data) state_next = DATA;
      DATA:    if (last_bit) state_next = PARITY_EN ? PARITY : STOP;
      PARITY:  state_next = STOP;
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_en  = 1'b0;
    shift_en  = 1'b0;
    parity_en = 1'b0;
    load_en   = 1'b0;
    case (state)
      IDLE:    start_en  = !data;
      DATA:    shift_en  = 1'b1;
      PARITY:  parity_en = 1'b1;
      STOP:    load_en   = 1'b1;
      default: ;
    endcase
  end

  // The counter parks on the last index rather than wrapping; a new start bit re-arms it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt    <= '0;
      payload    <= '0;
      parity_bit <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= load_en;
      busy  <= (state_next != IDLE);
      if (start_en) begin
        bit_cnt <= '0;
        payload <= '0;
      end
      if (shift_en) begin
        payload[bit_cnt] <= data;
        if (!last_bit) bit_cnt <= bit_cnt + CW'(1);
      end
      if (parity_en) parity_bit <= data;
      if (load_en) begin
        data_out   <= payload;
        parity_err <= PARITY_EN ? (^payload ^ parity_bit) : 1'b0;
        frame_err  <= ~data;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: one instance with default parity,
// one with parity disabled, sharing clock and reset.
module tb_serial_frame_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data = 1'b1;
  logic       data_np = 1'b1;
  logic [7:0] data_out, data_out_np;
  logic       valid, parity_err, frame_err, busy;
  logic       valid_np, parity_err_np, frame_err_np, busy_np;

  int n_checks = 0;
  int n_fail = 0;
  int cycles = 0;
  int t_first = 0;

  serial_frame_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  serial_frame_receiver #(.DATA_BITS(8), .PARITY_EN(1'b0)) dut_np (
    .clk        (clk),
    .rst        (rst),
    .data       (data_np),
    .data_out   (data_out_np),
    .valid      (valid_np),
    .parity_err (parity_err_np),
    .frame_err  (frame_err_np),
    .busy       (busy_np)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycles++;

  task automatic applyStimulus(input bit which, input bit value);
    if (which) data_np = value;
    else data = value;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendFrame(input bit which, input logic [7:0] payload,
                           input bit has_par, input bit par, input bit stop);
    applyStimulus(which, 1'b0);
    checkOutput("busy_after_start", which ? busy_np : busy, 1);
    for (int i = 0; i < 8; i++) applyStimulus(which, payload[i]);
    if (has_par) applyStimulus(which, par);
    checkOutput("valid_before_stop", which ? valid_np : valid, 0);
    applyStimulus(which, stop);
    checkOutput("valid_on_stop", which ? valid_np : valid, 1);
    checkOutput("busy_after_stop", which ? busy_np : busy, 0);
    if (which) data_np = 1'b1;
    else data = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b1);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_parity_err", parity_err, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_busy_np", busy_np, 0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_valid", valid, 0);
    end

    // Clean frame 0xA5, even parity 0
    sendFrame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    checkOutput("a5_data_out", data_out, 8'hA5);
    checkOutput("a5_parity_err", parity_err, 0);
    checkOutput("a5_frame_err", frame_err, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("a5_valid_one_cycle", valid, 0);
    checkOutput("a5_data_out_held", data_out, 8'hA5);

    // Parity error: 0x01 needs parity 1, send 0
    sendFrame(1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    checkOutput("pe_data_out", data_out, 8'h01);
    checkOutput("pe_parity_err", parity_err, 1);
    checkOutput("pe_frame_err", frame_err, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pe_valid_one_cycle", valid, 0);
    checkOutput("pe_parity_err_held", parity_err, 1);

    // Framing error, then two back-to-back frames with no idle bits
    sendFrame(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    checkOutput("fe_data_out", data_out, 8'h3C);
    checkOutput("fe_frame_err", frame_err, 1);
    checkOutput("fe_parity_err", parity_err, 0);
    sendFrame(1'b0, 8'h3C, 1'b1, 1'b0, 1'b1);
    t_first = cycles;
    checkOutput("b2b1_data_out", data_out, 8'h3C);
    checkOutput("b2b1_frame_err", frame_err, 0);
    checkOutput("b2b1_parity_err", parity_err, 0);
    sendFrame(1'b0, 8'hC3, 1'b1, 1'b0, 1'b1);
    checkOutput("b2b_gap", cycles - t_first, 11);
    checkOutput("b2b2_data_out", data_out, 8'hC3);
    checkOutput("b2b2_frame_err", frame_err, 0);
    checkOutput("b2b2_parity_err", parity_err, 0);

    // Reset during payload bit 4
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("mid_busy", busy, 1);
    checkOutput("mid_data_out_held", data_out, 8'hC3);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("midrst_data_out", data_out, 0);
    checkOutput("midrst_valid", valid, 0);
    checkOutput("midrst_parity_err", parity_err, 0);
    checkOutput("midrst_frame_err", frame_err, 0);
    checkOutput("midrst_busy", busy, 0);
    rst = 1'b1;
    sendFrame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
    checkOutput("5a_data_out", data_out, 8'h5A);
    checkOutput("5a_parity_err", parity_err, 0);
    checkOutput("5a_frame_err", frame_err, 0);

    // Reset on the stop edge wins over the load
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, (8'hA5 >> i) & 1'b1);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("stoprst_valid", valid, 0);
    checkOutput("stoprst_data_out", data_out, 0);
    checkOutput("stoprst_busy", busy, 0);
    rst = 1'b1;

    // No-parity instance: valid one edge earlier
    sendFrame(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    checkOutput("np_data_out", data_out_np, 8'hA5);
    checkOutput("np_parity_err", parity_err_np, 0);
    checkOutput("np_frame_err", frame_err_np, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("np_valid_one_cycle", valid_np, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
